knn_sequencer: RTL and testbench

Control sequencer for the KNN accelerator core (fifo/distance/k-sort datapath).
- Accepts a job command: number of training points to stream.
- Gates an input word stream into the core as one reference point followed by the training points, driving the core's wr_en/start.
- Waits out the pipeline drain, pulses done, then pulls the K results via rd_en and presents them on a valid/ready result port. Raises a completion pulse at the end.

---
 rtl/knn_seq_if.sv | 52 +++++
 rtl/knn_sequencer.sv | 155 +++++++++++++++
 tb/tb_knn_sequencer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/knn_seq_if.sv
// knn_seq_if: command, input-stream, core-side and result signals of knn_sequencer.
// When KNN_SEQ_PERF_EN is defined the interface also carries perf_cycles/perf_stalls.
interface knn_seq_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 1,
    parameter int PTS_WIDTH  = 16
) ();
    logic                         cmd_go;
    logic [PTS_WIDTH-1:0]         cmd_num_points;
    logic                         cmd_abort;
    logic                         busy;
    logic                         s_valid;
    logic                         s_ready;
    logic [NUM_CH*DATA_WIDTH-1:0] s_data;
    logic                         knn_wr_en;
    logic                         knn_start;
    logic                         knn_done;
    logic                         knn_rd_en;
    logic [NUM_CH*DATA_WIDTH-1:0] knn_data;
    logic [31:0]                  knn_name_in;
    logic [DATA_WIDTH-1:0]        knn_value_in;
    logic                         res_valid;
    logic                         res_ready;
    logic [31:0]                  res_name;
    logic [DATA_WIDTH-1:0]        res_value;
    logic                         res_last;
    logic                         irq_done;
`ifdef KNN_SEQ_PERF_EN
    logic [31:0]                  perf_cycles;
    logic [31:0]                  perf_stalls;
`endif

    modport master (
`ifdef KNN_SEQ_PERF_EN
        output perf_cycles, perf_stalls,
`endif
        input  cmd_go, cmd_num_points, cmd_abort, s_valid, s_data,
        input  knn_name_in, knn_value_in, res_ready,
        output busy, s_ready, knn_wr_en, knn_start, knn_done, knn_rd_en, knn_data,
        output res_valid, res_name, res_value, res_last, irq_done
    );

    modport slave (
`ifdef KNN_SEQ_PERF_EN
        input  perf_cycles, perf_stalls,
`endif
        output cmd_go, cmd_num_points, cmd_abort, s_valid, s_data,
        output knn_name_in, knn_value_in, res_ready,
        input  busy, s_ready, knn_wr_en, knn_start, knn_done, knn_rd_en, knn_data,
        input  res_valid, res_name, res_value, res_last, irq_done
    );
endinterface

// File: rtl/knn_sequencer.sv
// knn_sequencer: job sequencing, input gating and result readback for the KNN core.
// Optional KNN_SEQ_PERF_EN adds saturating busy-cycle and input-stall counters.
//
// state      | meaning
// IDLE       | waiting for cmd_go with a non-zero point count
// LOAD_REF   | streaming the reference point (knn_start on each beat)
// STREAM     | streaming groups*DIMENSIONS training beats
// DRAIN      | waiting DRAIN_CYCLES for the core pipeline to empty
// DONE_PULSE | knn_done for one cycle
// RD_REQ     | knn_rd_en for one cycle
// RD_CAP     | capture core result into res_* registers
// RD_WAIT    | hold result until res_ready
// FIN        | irq_done for one cycle
module knn_sequencer #(
    parameter int DATA_WIDTH   = 32,
    parameter int DIMENSIONS   = 32,
    parameter int NUM_CH       = 1,
    parameter int K            = 1,
    parameter int PTS_WIDTH    = 16,
    parameter int DRAIN_CYCLES = 4
) (
    input logic       mclk,
    input logic       reset,
    knn_seq_if.master bus
);
    localparam logic [3:0] IDLE       = 4'd0;
    localparam logic [3:0] LOAD_REF   = 4'd1;
    localparam logic [3:0] STREAM     = 4'd2;
    localparam logic [3:0] DRAIN      = 4'd3;
    localparam logic [3:0] DONE_PULSE = 4'd4;
    localparam logic [3:0] RD_REQ     = 4'd5;
    localparam logic [3:0] RD_CAP     = 4'd6;
    localparam logic [3:0] RD_WAIT    = 4'd7;
    localparam logic [3:0] FIN        = 4'd8;

    localparam int DIM_W = $clog2(DIMENSIONS + 1);
    localparam int GRP_W = PTS_WIDTH + 1;
    localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);
    localparam int K_W   = $clog2(K + 1);

    localparam logic [DIM_W-1:0] BEAT_LAST = DIM_W'(DIMENSIONS - 1);
    localparam logic [DRN_W-1:0] DRN_LOAD  = DRN_W'(DRAIN_CYCLES - 1);
    localparam logic [K_W-1:0]   K_LAST    = K_W'(K - 1);

    logic [3:0]            state, state_nxt;
    logic [DIM_W-1:0]      beat_cnt;
    logic [GRP_W-1:0]      group_cnt, groups_q, groups_calc;
    logic [DRN_W-1:0]      drain_cnt;
    logic [K_W-1:0]        rd_idx;
    logic                  in_load, beat, beat_wrap, last_group, handshake, go_ok;
    logic                  res_valid_q, res_last_q;
    logic [31:0]           res_name_q;
    logic [DATA_WIDTH-1:0] res_value_q;

    assign in_load     = (state == LOAD_REF) || (state == STREAM);
    assign beat        = bus.s_valid & in_load;
    assign beat_wrap   = beat && (beat_cnt == BEAT_LAST);
    assign last_group  = (group_cnt == groups_q - GRP_W'(1));
    assign handshake   = res_valid_q & bus.res_ready;
    assign go_ok       = (state == IDLE) && bus.cmd_go && (bus.cmd_num_points != '0);
    // Groups round up so a partially filled last lane group is still streamed.
    assign groups_calc = ({1'b0, bus.cmd_num_points} + GRP_W'(NUM_CH - 1)) / GRP_W'(NUM_CH);

    assign bus.s_ready   = in_load;
    assign bus.knn_wr_en = beat;
    assign bus.knn_start = beat & (state == LOAD_REF);
    assign bus.knn_done  = (state == DONE_PULSE);
    assign bus.knn_rd_en = (state == RD_REQ);
    assign bus.irq_done  = (state == FIN);
    assign bus.busy      = (state != IDLE);
    assign bus.knn_data  = bus.s_data;
    assign bus.res_valid = res_valid_q;
    assign bus.res_last  = res_last_q;
    assign bus.res_name  = res_name_q;
    assign bus.res_value = res_value_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (go_ok) state_nxt = LOAD_REF;
            LOAD_REF:   if (beat_wrap) state_nxt = STREAM;
            STREAM:     if (beat_wrap && last_group) state_nxt = DRAIN;
            DRAIN:      if (drain_cnt == '0) state_nxt = DONE_PULSE;
            DONE_PULSE: state_nxt = RD_REQ;
            RD_REQ:     state_nxt = RD_CAP;
            RD_CAP:     state_nxt = RD_WAIT;
            RD_WAIT:    if (handshake) state_nxt = (rd_idx == K_LAST) ? FIN : RD_REQ;
            FIN:        state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
        if (bus.cmd_abort && (state != IDLE)) state_nxt = IDLE;
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            group_cnt   <= '0;
            groups_q    <= '0;
            drain_cnt   <= '0;
            rd_idx      <= '0;
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
            res_name_q  <= '0;
            res_value_q <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt == IDLE) begin
                beat_cnt    <= '0;
                group_cnt   <= '0;
                drain_cnt   <= '0;
                rd_idx      <= '0;
                res_valid_q <= 1'b0;
                res_last_q  <= 1'b0;
            end else begin
                if (state == IDLE) groups_q <= groups_calc;
                if (beat) beat_cnt <= beat_wrap ? '0 : beat_cnt + DIM_W'(1);
                if ((state == STREAM) && beat_wrap) group_cnt <= group_cnt + GRP_W'(1);
                // Drain timer is preloaded while streaming and runs down to terminal count.
                if (state == STREAM) drain_cnt <= DRN_LOAD;
                else if ((state == DRAIN) && (drain_cnt != '0)) drain_cnt <= drain_cnt - DRN_W'(1);
                if (state == RD_CAP) begin
                    res_name_q  <= bus.knn_name_in;
                    res_value_q <= bus.knn_value_in;
                    res_valid_q <= 1'b1;
                    res_last_q  <= (rd_idx == K_LAST);
                end else if (handshake) begin
                    res_valid_q <= 1'b0;
                    res_last_q  <= 1'b0;
                    rd_idx      <= rd_idx + K_W'(1);
                end
            end
        end
    end

`ifdef KNN_SEQ_PERF_EN
    logic [31:0] perf_cycles_q, perf_stalls_q;

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            perf_cycles_q <= '0;
            perf_stalls_q <= '0;
        end else if (go_ok) begin
            perf_cycles_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            if ((state != IDLE) && (perf_cycles_q != '1)) perf_cycles_q <= perf_cycles_q + 32'd1;
            if (in_load && !bus.s_valid && (perf_stalls_q != '1)) perf_stalls_q <= perf_stalls_q + 32'd1;
        end
    end

    assign bus.perf_cycles = perf_cycles_q;
    assign bus.perf_stalls = perf_stalls_q;
`endif
endmodule

// File: tb/tb_knn_sequencer.sv
// Directed testbench for knn_sequencer: instance A (NUM_CH=1, K=1), instance B (NUM_CH=2, K=3).
`timescale 1ns/1ps
module tb_knn_sequencer;
    localparam int DW  = 32;
    localparam int DIM = 4;
    localparam int PW  = 16;
    localparam int DRN = 4;
    localparam logic [31:0] NAME_BASE = 32'h4E00_0010;
    localparam logic [31:0] VAL_BASE  = 32'h0000_1000;

    logic mclk  = 1'b0;
    logic reset = 1'b1;
    always #5 mclk = ~mclk;

    knn_seq_if #(.DATA_WIDTH(DW), .NUM_CH(1), .PTS_WIDTH(PW)) ifa ();
    knn_seq_if #(.DATA_WIDTH(DW), .NUM_CH(2), .PTS_WIDTH(PW)) ifb ();

    knn_sequencer #(.DATA_WIDTH(DW), .DIMENSIONS(DIM), .NUM_CH(1), .K(1),
                    .PTS_WIDTH(PW), .DRAIN_CYCLES(DRN))
        dut_a (.mclk(mclk), .reset(reset), .bus(ifa.master));
    knn_sequencer #(.DATA_WIDTH(DW), .DIMENSIONS(DIM), .NUM_CH(2), .K(3),
                    .PTS_WIDTH(PW), .DRAIN_CYCLES(DRN))
        dut_b (.mclk(mclk), .reset(reset), .bus(ifb.master));

    logic          sel = 1'b0;
    logic          go = 1'b0, abort = 1'b0, s_valid = 1'b0, res_ready = 1'b0;
    logic [PW-1:0] npts = '0;
    logic [63:0]   sdata = '0;
    logic [31:0]   name_in = '0;
    logic [DW-1:0] value_in = '0;

    assign ifa.cmd_go = go & ~sel;        assign ifb.cmd_go = go & sel;
    assign ifa.cmd_abort = abort & ~sel;  assign ifb.cmd_abort = abort & sel;
    assign ifa.cmd_num_points = npts;     assign ifb.cmd_num_points = npts;
    assign ifa.s_valid = s_valid;         assign ifb.s_valid = s_valid;
    assign ifa.s_data = sdata[DW-1:0];    assign ifb.s_data = sdata;
    assign ifa.knn_name_in = name_in;     assign ifb.knn_name_in = name_in;
    assign ifa.knn_value_in = value_in;   assign ifb.knn_value_in = value_in;
    assign ifa.res_ready = res_ready;     assign ifb.res_ready = res_ready;

    wire        m_busy  = sel ? ifb.busy      : ifa.busy;
    wire        m_srdy  = sel ? ifb.s_ready   : ifa.s_ready;
    wire        m_wr    = sel ? ifb.knn_wr_en : ifa.knn_wr_en;
    wire        m_start = sel ? ifb.knn_start : ifa.knn_start;
    wire        m_done  = sel ? ifb.knn_done  : ifa.knn_done;
    wire        m_rd    = sel ? ifb.knn_rd_en : ifa.knn_rd_en;
    wire        m_rv    = sel ? ifb.res_valid : ifa.res_valid;
    wire        m_last  = sel ? ifb.res_last  : ifa.res_last;
    wire        m_irq   = sel ? ifb.irq_done  : ifa.irq_done;
    wire [31:0] m_name  = sel ? ifb.res_name  : ifa.res_name;
    wire [31:0] m_value = sel ? ifb.res_value : ifa.res_value;
`ifdef KNN_SEQ_PERF_EN
    wire [31:0] m_pcyc  = sel ? ifb.perf_cycles : ifa.perf_cycles;
    wire [31:0] m_pstl  = sel ? ifb.perf_stalls : ifa.perf_stalls;
`endif

    int n_checks = 0, n_errors = 0;
    int n_wr, n_start, last_beat, n_done, done_cyc, n_rd, rd_cyc, rd_in_rv;
    int first_rv, rv_cycles, res_bad, n_irq, irq_cyc, end_cyc;
    logic [3:0] last_mask;
    logic busy_c1, rst_zero;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One job on the selected instance; cycle 1 is the cycle after cmd_go is sampled.
    task automatic run_job(input bit b, input int n, input bit tog, input int hold,
                           input int abort_beat, input bit rst_wait);
        int  c, rd_c, rv_run;
        bit  fin;
        sel = b;
        n_wr = 0; n_start = 0; last_beat = -1; n_done = 0; done_cyc = -1; n_rd = 0;
        rd_cyc = -1; rd_in_rv = 0; first_rv = -1; rv_cycles = 0; res_bad = 0;
        n_irq = 0; irq_cyc = -1; end_cyc = -1; last_mask = '0; busy_c1 = 1'b0; rst_zero = 1'b0;
        @(negedge mclk); go = 1'b1; npts = PW'(n);
        @(negedge mclk); go = 1'b0;
        c = 1; rd_c = -10; rv_run = 0; fin = 1'b0;
        while (!fin && c <= 400) begin
            s_valid   = tog ? c[0] : 1'b1;
            sdata     = {32'(c), 32'(c * 5)};
            name_in   = (c == rd_c + 1) ? 32'(NAME_BASE + 32'(n_rd - 1)) : 32'hDEAD_BEEF;
            value_in  = (c == rd_c + 1) ? 32'(VAL_BASE + 32'((n_rd - 1) * 7)) : 32'hBAD0_0BAD;
            res_ready = (rv_run >= hold);
            abort     = (abort_beat >= 0) && (n_wr == abort_beat);
            #1;
            if (c == 1) busy_c1 = m_busy;
            if (!m_busy) begin
                end_cyc = c; fin = 1'b1;
            end else begin
                if (m_wr) begin n_wr++; last_beat = c; end
                if (m_start) n_start++;
                if (m_done) begin n_done++; done_cyc = c; end
                if (m_rd) begin n_rd++; rd_cyc = c; rd_c = c; if (m_rv) rd_in_rv++; end
                if (m_rv) begin
                    if (first_rv < 0) first_rv = c;
                    rv_cycles++;
                    if (n_rd >= 1 && n_rd <= 4) last_mask[n_rd-1] = last_mask[n_rd-1] | m_last;
                    if (m_name !== 32'(NAME_BASE + 32'(n_rd - 1)) ||
                        m_value !== 32'(VAL_BASE + 32'((n_rd - 1) * 7))) res_bad++;
                    if (res_ready) rv_run = 0; else rv_run++;
                end
                if (m_irq) begin n_irq++; irq_cyc = c; end
                if (rst_wait && m_rv) begin
                    reset = 1'b1; #1;
                    rst_zero = ({m_busy, m_srdy, m_wr, m_start, m_done, m_rd, m_rv, m_last, m_irq} === 9'b0)
                               && (m_name === 32'b0) && (m_value === 32'b0);
                    end_cyc = c; fin = 1'b1;
                end
            end
            if (!fin) begin @(negedge mclk); c++; end
        end
        go = 1'b0; abort = 1'b0; s_valid = 1'b0; res_ready = 1'b0;
        chk("job_terminated", 64'(fin), 64'(1));
        if (reset) begin @(negedge mclk); reset = 1'b0; end
    endtask

    initial begin
        // Reset values and combinational data path
        @(negedge mclk); sdata = 64'h0123_4567_89AB_CDEF; #1;
        chk("rst_ctrl", 64'({m_busy, m_srdy, m_wr, m_start, m_done, m_rd, m_rv, m_last, m_irq}), 64'(0));
        chk("rst_res", 64'({m_name, m_value}), 64'(0));
        chk("knn_data_a", 64'(ifa.knn_data), 64'h89AB_CDEF);
        chk("knn_data_b", ifb.knn_data, 64'h0123_4567_89AB_CDEF);
        @(negedge mclk); reset = 1'b0;

        // A: 3 points, continuous input
        run_job(1'b0, 3, 1'b0, 0, -1, 1'b0);
        chk("t1_busy_c1", 64'(busy_c1), 64'(1));
        chk("t1_wr_beats", 64'(n_wr), 64'(16));
        chk("t1_start_beats", 64'(n_start), 64'(4));
        chk("t1_last_beat", 64'(last_beat), 64'(16));
        chk("t1_done_cyc", 64'(done_cyc), 64'(21));
        chk("t1_done_cnt", 64'(n_done), 64'(1));
        chk("t1_rd_cyc", 64'(rd_cyc), 64'(22));
        chk("t1_rd_cnt", 64'(n_rd), 64'(1));
        chk("t1_first_rv", 64'(first_rv), 64'(24));
        chk("t1_res_data", 64'(res_bad), 64'(0));
        chk("t1_res_last", 64'(last_mask), 64'(1));
        chk("t1_irq_cyc", 64'(irq_cyc), 64'(25));
        chk("t1_irq_cnt", 64'(n_irq), 64'(1));
        chk("t1_idle_cyc", 64'(end_cyc), 64'(26));

        // A: same job with s_valid toggling 1010...
        run_job(1'b0, 3, 1'b1, 0, -1, 1'b0);
        chk("t2_wr_beats", 64'(n_wr), 64'(16));
        chk("t2_start_beats", 64'(n_start), 64'(4));
        chk("t2_last_beat", 64'(last_beat), 64'(31));
        chk("t2_done_cyc", 64'(done_cyc), 64'(36));
        chk("t2_irq_cyc", 64'(irq_cyc), 64'(40));
        chk("t2_res_data", 64'(res_bad), 64'(0));
`ifdef KNN_SEQ_PERF_EN
        chk("t2_perf_stalls", 64'(m_pstl), 64'(15));
        chk("t2_perf_cycles", 64'(m_pcyc), 64'(40));
`endif

        // B: NUM_CH=2, K=3, 3 points, consumer holds off 5 cycles per result
        run_job(1'b1, 3, 1'b0, 5, -1, 1'b0);
        chk("t3_wr_beats", 64'(n_wr), 64'(12));
        chk("t3_start_beats", 64'(n_start), 64'(4));
        chk("t3_done_cyc", 64'(done_cyc), 64'(17));
        chk("t3_rd_cnt", 64'(n_rd), 64'(3));
        chk("t3_rd_last_cyc", 64'(rd_cyc), 64'(34));
        chk("t3_rd_while_valid", 64'(rd_in_rv), 64'(0));
        chk("t3_rv_cycles", 64'(rv_cycles), 64'(18));
        chk("t3_res_data", 64'(res_bad), 64'(0));
        chk("t3_res_last", 64'(last_mask), 64'(4));
        chk("t3_irq_cyc", 64'(irq_cyc), 64'(42));

        // A: abort on beat 6 (third STREAM beat), then a clean job
        run_job(1'b0, 3, 1'b0, 0, 6, 1'b0);
        chk("t4_wr_beats", 64'(n_wr), 64'(7));
        chk("t4_idle_cyc", 64'(end_cyc), 64'(8));
        chk("t4_no_done", 64'(n_done), 64'(0));
        chk("t4_no_irq", 64'(n_irq), 64'(0));
        run_job(1'b0, 2, 1'b0, 0, -1, 1'b0);
        chk("t5_wr_beats", 64'(n_wr), 64'(12));
        chk("t5_done_cyc", 64'(done_cyc), 64'(17));
        chk("t5_irq_cyc", 64'(irq_cyc), 64'(21));
        chk("t5_res_data", 64'(res_bad), 64'(0));

        // A: zero-point command is ignored
        run_job(1'b0, 0, 1'b0, 0, -1, 1'b0);
        chk("t6_busy_c1", 64'(busy_c1), 64'(0));
        chk("t6_no_irq", 64'(n_irq), 64'(0));

        // A: reset while result is held, then a normal job
        run_job(1'b0, 1, 1'b0, 3, -1, 1'b1);
        chk("t7_rst_cyc", 64'(end_cyc), 64'(16));
        chk("t7_rst_zero", 64'(rst_zero), 64'(1));
        chk("t7_no_irq", 64'(n_irq), 64'(0));
        run_job(1'b0, 1, 1'b0, 0, -1, 1'b0);
        chk("t8_wr_beats", 64'(n_wr), 64'(8));
        chk("t8_irq_cyc", 64'(irq_cyc), 64'(17));
        chk("t8_res_data", 64'(res_bad), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
